// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, op-select encodings and sizing helpers
package muldiv_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE} state_t;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration on magnitudes
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_part,
  input  logic [WIDTH-1:0]   i_mag,
  input  logic               i_is_div,
  output logic [2*WIDTH-1:0] o_part,
  output logic               o_qbit
);
  logic [WIDTH:0] w_sum, w_diff;
  assign w_sum  = {1'b0, i_part[2*WIDTH-1:WIDTH]} + {1'b0, i_mag & {WIDTH{i_part[0]}}};
  // remainder stays below the divisor, so the shifted value minus divisor fits WIDTH+1 signed bits
  assign w_diff = i_part[2*WIDTH-1:WIDTH-1] - {1'b0, i_mag};
  assign o_qbit = i_is_div & ~w_diff[WIDTH];
  assign o_part = !i_is_div ? {w_sum, i_part[WIDTH-1:1]} :
                  o_qbit    ? {w_diff[WIDTH-1:0], i_part[WIDTH-2:0], 1'b0} :
                              {i_part[2*WIDTH-2:0], 1'b0};
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply/divide with HI/LO result and flush cancel
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mag, r_hi, r_lo;
  logic               r_div, r_neg, r_neg_rem, r_busy, r_ready, r_dbz;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_mul, w_fast, w_fix, w_step;
  logic               w_neg, w_dz, w_fast_path, w_accept, w_qbit;

  assign w_a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_neg       = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_dz        = (is_div == OP_DIV) && (b == '0);
  assign w_fast_path = w_dz || (FAST_MUL && is_div == OP_MUL);
  assign w_mul       = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
  assign w_fast      = w_dz ? {a, {WIDTH{1'b1}}} : (w_neg ? -w_mul : w_mul);
  assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  // remainder follows the dividend sign, quotient and product follow the sign difference
  assign w_fix = r_div ? {(r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH]),
                          (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0])}
                       : (r_neg ? -r_acc : r_acc);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_part  (r_acc),
    .i_mag   (r_mag),
    .i_is_div(r_div),
    .o_part  (w_step),
    .o_qbit  (w_qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mag     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_div     <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (cancel) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else if (w_accept) begin
      r_div     <= is_div;
      r_neg     <= w_neg;
      r_neg_rem <= is_signed & a[WIDTH-1];
      r_dbz     <= w_dz;
      r_cnt     <= '0;
      r_acc     <= {{WIDTH{1'b0}}, is_div ? w_a_mag : w_b_mag};
      r_mag     <= is_div ? w_b_mag : w_a_mag;
      r_state   <= w_fast_path ? ST_DONE : ST_CALC;
      r_busy    <= !w_fast_path;
      r_ready   <= w_fast_path;
      if (w_fast_path) {r_hi, r_lo} <= w_fast;
    end else if (r_state == ST_CALC) begin
      r_acc <= {w_step[2*WIDTH-1:1], w_step[0] | w_qbit};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH-1)) r_state <= ST_FIXUP;
    end else if (r_state == ST_FIXUP) begin
      {r_hi, r_lo} <= w_fix;
      r_state      <= ST_DONE;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end
  end

  assign busy        = r_busy;
  assign ready       = r_ready;
  assign result_hi   = r_hi;
  assign result_lo   = r_lo;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for the iterative and fast-multiply configurations
module tb_muldiv_iter;
  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
    int          lat, sc, id;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, start_f = 1'b0, cancel = 1'b0;
  logic        is_div = 1'b0, is_signed = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, ready, dbz, busy_f, ready_f, dbz_f;
  logic [31:0] hi, lo, hi_f, lo_f;
  exp_t        q0[$], q1[$];
  int          nchk = 0, nfail = 0, cyc = 0, busy_n = 0, busy_f_n = 0, nid = 0;

  muldiv_iter #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .is_div(is_div), .is_signed(is_signed),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .ready(ready),
    .result_hi(hi), .result_lo(lo), .div_by_zero(dbz)
  );
  muldiv_iter #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .is_div(is_div), .is_signed(is_signed),
    .a(a), .b(b), .cancel(cancel), .busy(busy_f), .ready(ready_f),
    .result_hi(hi_f), .result_lo(lo_f), .div_by_zero(dbz_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic mon(input int u, input logic [31:0] rh, input logic [31:0] rl, input logic rdz);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      nchk++;
      nfail++;
      $display("FAIL spurious_ready unit%0d: got ready=1 expected ready=0", u);
      return;
    end
    if (u == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("op%0d_hi", e.id), rh, e.hi);
    chk($sformatf("op%0d_lo", e.id), rl, e.lo);
    chk($sformatf("op%0d_dz", e.id), {31'd0, rdz}, {31'd0, e.dz});
    chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.sc), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_n++;
      if (busy_f) busy_f_n++;
      if (ready) mon(0, hi, lo, dbz);
      if (ready_f) mon(1, hi_f, lo_f, dbz_f);
    end
  end

  // drives one start cycle from posedge+1 and returns at posedge+1 of the next cycle
  task automatic go(input logic f, input logic d, input logic s, input logic [31:0] x,
                    input logic [31:0] y, input logic push, input logic [31:0] ehi,
                    input logic [31:0] elo, input logic edz, input int lat);
    exp_t e;
    is_div = d; is_signed = s; a = x; b = y;
    if (f) start_f = 1'b1;
    else start = 1'b1;
    if (push) begin
      nid++;
      e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = lat; e.sc = cyc; e.id = nid;
      if (f) q1.push_back(e);
      else q0.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0; start_f = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0BADF00D; is_div = ~d; is_signed = ~s;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    nchk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    int b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_dz", {31'd0, dbz}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // iterative multiply, busy must cover cycles 1..33
    b0 = busy_n;
    go(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, 34);
    drain(100);
    chk("mul_busy_cycles", 32'(busy_n - b0), 32'd33);
    go(0, 0, 1, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34);
    drain(100);
    go(0, 0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0, 34);
    drain(100);
    // single-cycle multiply configuration
    b0 = busy_f_n;
    go(1, 0, 1, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 1);
    drain(10);
    go(1, 0, 1, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0, 1);
    drain(10);
    go(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, 1);
    drain(10);
    chk("fast_busy_cycles", 32'(busy_f_n - b0), 32'd0);
    // divides: signs, overflow case, unsigned wide dividend
    go(0, 1, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
    drain(100);
    go(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0, 34);
    drain(100);
    go(0, 1, 1, 32'd7, 32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 0, 34);
    drain(100);
    go(0, 1, 0, 32'hFFFFFFFF, 32'h10, 1, 32'h0000000F, 32'h0FFFFFFF, 0, 34);
    drain(100);
    // divide by zero takes the fast path
    b0 = busy_n;
    go(0, 1, 0, 32'd100, 32'd0, 1, 32'd100, 32'hFFFFFFFF, 1, 1);
    drain(10);
    chk("dz_busy_cycles", 32'(busy_n - b0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("dz_holds", {31'd0, dbz}, 32'd1);
    go(0, 1, 1, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 1);
    drain(10);
    go(0, 0, 0, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0, 34);
    chk("dz_cleared_on_start", {31'd0, dbz}, 32'd0);
    drain(100);
    // cancel mid-CALC: no ready, results held
    go(0, 1, 0, 32'd1000, 32'd7, 0, '0, '0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hold_hi", hi, 32'd0);
    chk("cancel_hold_lo", lo, 32'd12);
    go(0, 1, 0, 32'd1000, 32'd7, 1, 32'd6, 32'd142, 0, 34);
    repeat (33) @(posedge clk);
    #1;
    go(0, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 32'd0, 32'd6, 0, 34);
    drain(100);
    // cancel wins over a simultaneous start, even on the fast path
    is_div = 1'b0; is_signed = 1'b0; a = 32'd9; b = 32'd9;
    start = 1'b1; start_f = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start_f = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", {31'd0, busy}, 32'd0);
    chk("cancel_start_ready_f", {31'd0, ready_f}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    // asynchronous reset mid-CALC
    go(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, '0, '0, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    chk("async_rst_dz", {31'd0, dbz}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    go(0, 0, 0, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 34);
    drain(100);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
